// File: rtl/dmem_port_arbiter_if.sv
// Requester-side bundle for the two-port data memory arbiter.
// The arbiter takes the slave view; requesters (or a bench) drive the master view.
interface dmem_port_arbiter_if;
    logic       req0;
    logic       req1;
    logic       we0;
    logic       we1;
    logic       lock0;
    logic       lock1;
    logic [7:0] addr0;
    logic [7:0] addr1;
    logic [7:0] wd0;
    logic [7:0] wd1;
    logic       gnt0;
    logic       gnt1;
    logic       rvalid0;
    logic       rvalid1;
    logic [7:0] rdata0;
    logic [7:0] rdata1;
    logic       err0;
    logic       err1;

    modport master (
        output req0, req1, we0, we1, lock0, lock1, addr0, addr1, wd0, wd1,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1
    );

    modport slave (
        input  req0, req1, we0, we1, lock0, lock1, addr0, addr1, wd0, wd1,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing a single-port 8-bit data memory between the CPU (port 0)
// and the DMA/debug loader (port 1), with a bounded lock for read-modify-write sequences.
module dmem_port_arbiter #(
    parameter int DEPTH    = 32,
    parameter int LOCK_MAX = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    dmem_port_arbiter_if.slave   bus,
    output logic [7:0]           mem_addr,
    output logic [7:0]           mem_wdata,
    output logic                 mem_read,
    output logic                 mem_write,
    input  logic [7:0]           mem_rdata
);

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_0    = 2'd1;
    localparam logic [1:0] OWN_1    = 2'd2;

    localparam logic [3:0] LOCK_LIM  = 4'(LOCK_MAX);
    localparam logic [8:0] DEPTH_LIM = 9'(DEPTH);

    logic [1:0] owner;
    logic       last;
    logic [3:0] lock_cnt;

    logic       grant0;
    logic       grant1;
    logic       any_gnt;
    logic       sel_port;
    logic       sel_we;
    logic       sel_lock;
    logic       sel_ok;
    logic       other_req;
    logic [1:0] sel_own;
    logic [7:0] sel_addr;
    logic [7:0] sel_wd;

    logic       rvalid0_p1;
    logic       rvalid1_p1;
    logic       err0_p1;
    logic       err1_p1;
    logic [7:0] rdata0_p1;
    logic [7:0] rdata1_p1;

    function automatic logic in_range(input logic [7:0] a);
        return {1'b0, a} < DEPTH_LIM;
    endfunction

    // A locked owner keeps the port until it drops req or exhausts its budget;
    // otherwise a tie goes to the port that did not complete last.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!reset) begin
            if (owner == OWN_0 && bus.req0 && lock_cnt < LOCK_LIM) begin
                grant0 = 1'b1;
            end else if (owner == OWN_1 && bus.req1 && lock_cnt < LOCK_LIM) begin
                grant1 = 1'b1;
            end else if (bus.req0 && bus.req1) begin
                grant0 = last;
                grant1 = ~last;
            end else begin
                grant0 = bus.req0;
                grant1 = bus.req1;
            end
        end
    end

    always_comb begin
        sel_port  = 1'b0;
        sel_we    = 1'b0;
        sel_lock  = 1'b0;
        sel_addr  = 8'd0;
        sel_wd    = 8'd0;
        other_req = 1'b0;
        sel_own   = OWN_NONE;
        if (grant0) begin
            sel_port  = 1'b0;
            sel_we    = bus.we0;
            sel_lock  = bus.lock0;
            sel_addr  = bus.addr0;
            sel_wd    = bus.wd0;
            other_req = bus.req1;
            sel_own   = OWN_0;
        end else if (grant1) begin
            sel_port  = 1'b1;
            sel_we    = bus.we1;
            sel_lock  = bus.lock1;
            sel_addr  = bus.addr1;
            sel_wd    = bus.wd1;
            other_req = bus.req0;
            sel_own   = OWN_1;
        end
    end

    assign any_gnt   = grant0 | grant1;
    assign sel_ok    = in_range(sel_addr);
    assign mem_addr  = sel_addr;
    assign mem_wdata = sel_wd;
    assign mem_write = any_gnt & sel_we & sel_ok;
    assign mem_read  = any_gnt & ~sel_we & sel_ok;

    assign bus.gnt0 = grant0;
    assign bus.gnt1 = grant1;

    // Granting the non-owner while a lock is held is the forced release: ownership is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner    <= OWN_NONE;
            last     <= 1'b1;
            lock_cnt <= 4'd0;
        end else if (any_gnt) begin
            last <= sel_port;
            if (owner != OWN_NONE && owner != sel_own) begin
                owner    <= OWN_NONE;
                lock_cnt <= 4'd0;
            end else if (sel_lock) begin
                owner <= sel_own;
                if (other_req && lock_cnt < LOCK_LIM) begin
                    lock_cnt <= lock_cnt + 4'd1;
                end
            end else begin
                owner    <= OWN_NONE;
                lock_cnt <= 4'd0;
            end
        end
    end

    // Stage p1: response strobes and read data one cycle after the completing edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid0_p1 <= 1'b0;
            rvalid1_p1 <= 1'b0;
            err0_p1    <= 1'b0;
            err1_p1    <= 1'b0;
            rdata0_p1  <= 8'd0;
            rdata1_p1  <= 8'd0;
        end else begin
            rvalid0_p1 <= grant0 & ~sel_we;
            rvalid1_p1 <= grant1 & ~sel_we;
            err0_p1    <= grant0 & ~sel_ok;
            err1_p1    <= grant1 & ~sel_ok;
            if (grant0 && !sel_we) begin
                rdata0_p1 <= sel_ok ? mem_rdata : 8'd0;
            end
            if (grant1 && !sel_we) begin
                rdata1_p1 <= sel_ok ? mem_rdata : 8'd0;
            end
        end
    end

    assign bus.rvalid0 = rvalid0_p1;
    assign bus.rvalid1 = rvalid1_p1;
    assign bus.err0    = err0_p1;
    assign bus.err1    = err1_p1;
    assign bus.rdata0  = rdata0_p1;
    assign bus.rdata1  = rdata1_p1;

endmodule
